// File: rtl/sff_pkg.sv
// Shared types and defaults for the synchronous-FIFO burst reader.
// Defaults track the 8-bit FIFO this block reads from.
package sff_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_LEN_W = 8;
    localparam int BUF_DEPTH = 2;
    localparam int CNT_W     = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } sff_state_e;

endpackage

// File: rtl/sff_out_buf.sv
// Two-entry FIFO-ordered output buffer; entry 0 is always the head.
// The caller guarantees no push when full and no pop when empty.
module sff_out_buf
    import sff_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push_last,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head_data,
    output logic             head_last
);

    logic [WIDTH-1:0] data1;
    logic             last1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count     <= '0;
            head_data <= '0;
            head_last <= 1'b0;
            data1     <= '0;
            last1     <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == '0) begin
                        head_data <= push_data;
                        head_last <= push_last;
                    end else begin
                        data1 <= push_data;
                        last1 <= push_last;
                    end
                    count <= count + CNT_W'(1);
                end
                2'b01: begin
                    head_data <= data1;
                    head_last <= last1;
                    count     <= count - CNT_W'(1);
                end
                2'b11: begin
                    // Count stays put; with one entry the new word becomes the head.
                    if (count == CNT_W'(1)) begin
                        head_data <= push_data;
                        head_last <= push_last;
                    end else begin
                        head_data <= data1;
                        head_last <= last1;
                        data1     <= push_data;
                        last1     <= push_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sff_burst_reader.sv
// Drains a fixed-length burst from a registered-output FIFO onto a
// valid/ready stream (valid holds until ready; a word moves when both are high).
module sff_burst_reader
    import sff_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last
);

    sff_state_e       state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] issued;
    logic [LEN_W-1:0] delivered;
    logic             inflight;
    logic [CNT_W-1:0] buf_cnt;
    logic             pop;
    logic [CNT_W:0]   occupancy;
    logic [LEN_W:0]   cap_idx;
    logic             push_last;

    assign pop     = m_valid & m_ready;
    assign m_valid = (buf_cnt != '0);

    // Credit counts the word leaving this cycle, so a full pipe still streams 1 word/cycle.
    assign occupancy  = {1'b0, buf_cnt} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};
    assign fifo_rd_en = (state == RUN) && !fifo_empty && (issued != len_q)
                        && (occupancy < (CNT_W+1)'(BUF_DEPTH));

    // Zero-based index of the word being captured is delivered + words already buffered.
    assign cap_idx   = {1'b0, delivered} + (LEN_W+1)'(buf_cnt);
    assign push_last = (cap_idx == ({1'b0, len_q} - (LEN_W+1)'(1)));

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            len_q     <= '0;
            issued    <= '0;
            delivered <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
            if (fifo_rd_en) issued <= issued + LEN_W'(1);
            if (pop) delivered <= delivered + LEN_W'(1);
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q     <= len;
                        issued    <= '0;
                        delivered <= '0;
                        state     <= (len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (issued == len_q) state <= DRAIN;
                end
                DRAIN: begin
                    if (pop && (delivered == len_q - LEN_W'(1))) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    sff_out_buf #(
        .WIDTH(WIDTH)
    ) u_out_buf (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight),
        .push_data(fifo_dout),
        .push_last(push_last),
        .pop      (pop),
        .count    (buf_cnt),
        .head_data(m_data),
        .head_last(m_last)
    );

endmodule

// File: tb/tb_sff_burst_reader.sv
// Bench for sff_burst_reader: behavioural FIFO, random writer/consumer,
// expected-word queue and a negedge monitor holding the burst-level model.
module tb_sff_burst_reader;
  localparam int WIDTH = 8;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             done;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_dout;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  int               fifo_level;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] pend_q[$];

  int vec_cnt = 0;
  int err_cnt = 0;
  int rdy_prob = 100;
  int wr_prob = 100;
  int cyc = 0;
  int rd_cnt = 0;
  int pop_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int start_cyc = 0;

  int mdl_busy = 0;
  int done_due = 0;
  int burst_left = 0;

  sff_burst_reader #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy), .done(done),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // behavioural FIFO with registered read data
  initial begin
    fifo_dout = '0;
    fifo_level = 0;
  end
  assign fifo_empty = (fifo_level == 0);

  always @(posedge clk) begin
    if (fifo_rd_en && fifo_q.size() != 0) fifo_dout <= fifo_q.pop_front();
    if (wr_en) fifo_q.push_back(wr_data);
    fifo_level <= fifo_q.size();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic push_word(input logic [WIDTH-1:0] d);
    pend_q.push_back(d);
    exp_q.push_back(d);
  endtask

  task automatic flush_writes();
    for (int i = 0; i < 500 && pend_q.size() != 0; i++) tick();
    tick();
    tick();
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    len = LEN_W'(n);
    tick();
    start = 1'b0;
    len = '0;
  endtask

  task automatic wait_done(input int d0, input int budget, input string tag);
    for (int i = 0; i < budget && done_cnt == d0; i++) tick();
    check(tag, done_cnt != d0, 1);
    tick();
  endtask

  task automatic run_burst(input int n, input int budget, input string tag);
    int d0;
    d0 = done_cnt;
    do_start(n);
    wait_done(d0, budget, tag);
  endtask

  // FIFO writer
  initial begin
    wr_en = 1'b0;
    wr_data = '0;
    forever begin
      tick();
      if (pend_q.size() != 0 && $urandom_range(1, 100) <= wr_prob) begin
        wr_en = 1'b1;
        wr_data = pend_q.pop_front();
      end else begin
        wr_en = 1'b0;
      end
    end
  end

  // consumer
  initial begin
    m_ready = 1'b0;
    forever begin
      tick();
      m_ready = ($urandom_range(1, 100) <= rdy_prob);
    end
  end

  // monitor + scoreboard
  initial begin
    logic [WIDTH-1:0] e;
    int nxt_done;
    forever begin
      @(negedge clk);
      cyc++;
      nxt_done = 0;
      if (fifo_rd_en) rd_cnt++;
      if (m_valid && m_ready) pop_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (!rst) begin
        mdl_busy = 0;
        done_due = 0;
        burst_left = 0;
        // words already pulled out of the FIFO by an aborted burst are lost
        while (exp_q.size() > fifo_q.size() + pend_q.size()) void'(exp_q.pop_front());
      end else begin
        if (fifo_empty) check("no_underflow", fifo_rd_en, 0);
        check("done", done, done_due);
        check("busy", busy, mdl_busy);
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0 || burst_left == 0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL unexpected_word: got %0h expected no word (cycle %0d)", m_data, cyc);
          end else begin
            e = exp_q.pop_front();
            check("m_data", m_data, e);
            check("m_last", m_last, burst_left == 1);
            burst_left--;
            if (burst_left == 0) nxt_done = 1;
          end
        end
        if (done_due != 0) begin
          done_due = 0;
          mdl_busy = 0;
        end else if (nxt_done != 0) begin
          done_due = 1;
        end else if (mdl_busy == 0 && start) begin
          mdl_busy = 1;
          start_cyc = cyc;
          if (len == '0) done_due = 1;
          else burst_left = int'(len);
        end
      end
    end
  end

  // stimulus
  initial begin
    int d0, r0, p0, n;
    rst = 1'b0;
    start = 1'b0;
    len = '0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    rst = 1'b1;
    tick();

    // full-rate burst
    push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
    flush_writes();
    r0 = rd_cnt;
    run_burst(4, 100, "t1_timeout");
    check("t1_rd_pulses", rd_cnt - r0, 4);
    check("t1_done_latency", done_cyc - start_cyc, 7);

    // FIFO runs dry mid-burst
    push_word(8'hA1);
    flush_writes();
    d0 = done_cnt;
    do_start(3);
    repeat (5) tick();
    push_word(8'hA2);
    repeat (15) tick();
    check("t2_stalled_busy", busy, 1);
    check("t2_no_done", done_cnt - d0, 0);
    push_word(8'hA3);
    wait_done(d0, 100, "t2_timeout");

    // consumer stalls
    for (int i = 0; i < 6; i++) push_word(WIDTH'($urandom_range(0, 255)));
    flush_writes();
    rdy_prob = 0;
    tick();
    d0 = done_cnt;
    r0 = rd_cnt;
    p0 = pop_cnt;
    do_start(6);
    repeat (10) tick();
    check("t3_rd_bound", (rd_cnt - r0) <= 2, 1);
    check("t3_no_pop", pop_cnt - p0, 0);
    rdy_prob = 100;
    wait_done(d0, 100, "t3_timeout");

    // zero-length burst
    r0 = rd_cnt;
    run_burst(0, 10, "t4_timeout");
    check("t4_no_reads", rd_cnt - r0, 0);

    // reset mid-burst with a read in flight
    for (int i = 0; i < 8; i++) push_word(WIDTH'($urandom_range(0, 255)));
    flush_writes();
    d0 = done_cnt;
    do_start(5);
    repeat (3) tick();
    for (int i = 0; i < 20 && !fifo_rd_en; i++) tick();
    tick();
    rst = 1'b0;
    tick();
    check("t5_m_valid", m_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_m_data", m_data, 0);
    tick();
    rst = 1'b1;
    tick();
    check("t5_no_done", done_cnt - d0, 0);
    run_burst(2, 100, "t5_timeout");
    n = fifo_q.size();
    if (n > 0) run_burst(n, 200, "t5_drain_timeout");

    // start during RUN is ignored
    for (int i = 0; i < 9; i++) push_word(WIDTH'($urandom_range(0, 255)));
    flush_writes();
    rdy_prob = 50;
    d0 = done_cnt;
    do_start(5);
    repeat (2) tick();
    do_start(9);
    wait_done(d0, 200, "t6_timeout");
    repeat (3) tick();
    check("t6_fifo_left", fifo_q.size(), 4);
    rdy_prob = 100;
    run_burst(4, 100, "t6_drain_timeout");

    // randomized bursts
    for (int b = 0; b < 10; b++) begin
      n = $urandom_range(1, 12);
      rdy_prob = $urandom_range(30, 100);
      wr_prob = $urandom_range(40, 100);
      for (int i = 0; i < n; i++) push_word(WIDTH'($urandom_range(0, 255)));
      run_burst(n, 500, "rand_timeout");
    end

    repeat (5) tick();
    check("leftover_words", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/sff_burst_reader.md
Name: sff_burst_reader

Overview:
- Read-side controller for the team's synchronous FIFO. The FIFO has registered read data: dout is valid the cycle after rd_en is sampled with the FIFO non-empty.
- On a start command, the block drains exactly len words from the FIFO and presents them on a valid/ready stream, with a last marker and a done pulse.
- It sits between the FIFO read port and any downstream consumer.
- It never underflows the FIFO. It never drops a word while the consumer stalls.

Parameters:
- WIDTH, 8: data width; must equal the FIFO WIDTH.
- LEN_W, 8: burst-length width. Maximum burst is 2^LEN_W-1 words.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-low reset.
- start  input  1  burst request pulse; sampled only in IDLE.
- len  input  LEN_W  burst length in words; sampled with start.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse when a burst has fully completed.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_en  output  1  FIFO read enable.
- fifo_dout  input  WIDTH  FIFO read data; valid 1 cycle after an accepted rd_en.
- m_valid  output  1  output word valid.
- m_ready  input  1  consumer ready.
- m_data  output  WIDTH  output word.
- m_last  output  1  high with the final word of the burst.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE; all counters=0; the 2-entry output buffer is emptied; in-flight flag=0.
  - Outputs: busy=0, done=0, fifo_rd_en=0, m_valid=0, m_data=0, m_last=0.
  - Reset mid-burst aborts the burst. Any in-flight FIFO word is discarded and no done pulse is issued.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN: start=1 and len!=0. Latch len; clear the issued and delivered counters.
  - IDLE→DONE: start=1 and len==0. No reads are issued.
  - RUN→DRAIN: issued==len at the clock edge, i.e. all reads have been issued.
  - DRAIN→DONE: on the handshake (m_valid&m_ready) of the word where delivered reaches len.
  - DONE→IDLE: unconditional. done=1 only during the DONE cycle.
  - start is ignored in any state other than IDLE.
- Read issue (combinational): fifo_rd_en = (state==RUN) & !fifo_empty & (issued!=len) & (buf_cnt + inflight - pop < 2), where pop = m_valid&m_ready.
  - The term that depends on m_ready is intentional. It gives sustained 1 word/cycle throughput with buf_cnt=1, inflight=1.
  - The block never asserts rd_en while fifo_empty=1.
- Read pipeline:
  - An accepted rd_en sets inflight=1 for the next cycle.
  - In that next cycle, fifo_dout is written into the 2-entry output buffer (FIFO order).
  - Latency from rd_en to earliest m_valid is 2 cycles: capture edge, then the buffer head is registered.
- Output stream:
  - m_valid = (buf_cnt != 0).
  - m_data and m_last come from the buffer head and are held stable while m_valid & !m_ready.
  - m_last is high iff the head word is word number len, i.e. delivered==len-1.
  - A push and a pop in the same cycle leave buf_cnt unchanged.
  - The buffer can never overflow, by the credit rule above.
- Counters:
  - issued increments on each accepted rd_en; delivered increments on each handshake. Both are LEN_W bits and cannot wrap, since both are ≤ len.
- busy = (state != IDLE); it is high during DONE.

Decomposition:
- Shared package sff_pkg: state enum type (IDLE, RUN, DRAIN, DONE) and the buffer-depth constant (2). The package also holds the default WIDTH/LEN_W values, matching the FIFO's 8-bit width.
- One sub-module is natural: sff_out_buf, the 2-entry valid/ready buffer with push, pop, count and head data/last.

Test Plan:
- len=4; FIFO preloaded with 0x11,0x22,0x33,0x44; m_ready=1 → 4 rd_en pulses; m_data 0x11..0x44 on consecutive cycles; m_last only with 0x44; done pulse 1 cycle after the 0x44 handshake; busy falls the cycle after done.
- len=3; FIFO holds 1 word; a second word is written 5 cycles later → rd_en never high while fifo_empty=1; the burst stalls in RUN. The burst stalls again once the second word is read, because the third word never arrives (busy stays 1, no done); then a third word is written and the burst completes.
- len=6; m_ready held 0 for 10 cycles, then 1 → at most 2 rd_en before output; m_data frozen at the first word; no words lost; all 6 words delivered in order after release.
- start with len=0 → no rd_en; done=1 on the next cycle; busy high for exactly 1 cycle.
- rst=0 asserted mid-burst with inflight=1 → next cycle: m_valid=0, busy=0, no done. A new burst with len=2 returns the next two FIFO words.
- start pulsed again during RUN with len=9 → ignored; the original burst count is unaffected.
